// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the multi-channel push-button conditioner.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        PRESSED  = 3'd2,
        HELD     = 3'd3,
        REL_WAIT = 3'd4
    } btn_state_t;

    localparam int DB_CYC_DEF   = 100000;
    localparam int HOLD_CYC_DEF = 50000000;
    localparam int RPT_CYC_DEF  = 10000000;

    // Width that holds the largest of the three cycle counts without wrapping.
    function automatic int cnt_width(input int db, input int hold, input int rpt);
        int m;
        m = db;
        if (hold > m) begin
            m = hold;
        end else begin
            m = m;
        end
        if (rpt > m) begin
            m = rpt;
        end else begin
            m = m;
        end
        if ($clog2(m + 1) < 1) begin
            return 1;
        end else begin
            return $clog2(m + 1);
        end
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, stability filter FSM, hold/repeat
// counters and registered level/pulse outputs.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DB_CYC     = DB_CYC_DEF,
    parameter int HOLD_CYC   = HOLD_CYC_DEF,
    parameter int RPT_CYC    = RPT_CYC_DEF,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_hold,
    output logic o_repeat
);

    localparam int CW = cnt_width(DB_CYC, HOLD_CYC, RPT_CYC);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] C_DB   = CW'(DB_CYC);
    localparam logic [CW-1:0] C_HOLD = CW'(HOLD_CYC);
    localparam logic [CW-1:0] C_RPT  = CW'(RPT_CYC);
    localparam bit DB_ONE = (DB_CYC <= 1);
    localparam bit RPT_EN = (RPT_CYC != 0);

    logic          r_sync1;
    logic          r_sync2;
    btn_state_t    r_state;
    logic          r_ret_held;
    logic [CW-1:0] r_db_cnt;
    logic [CW-1:0] r_hold_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          r_hold;
    logic          r_repeat;

    logic          w_s;
    logic [CW-1:0] w_db_inc;
    logic [CW-1:0] w_hold_inc;
    btn_state_t    w_state_nxt;
    logic          w_ret_held_nxt;
    logic [CW-1:0] w_db_nxt;
    logic [CW-1:0] w_hold_nxt;
    logic          w_level_nxt;
    logic          w_press_nxt;
    logic          w_release_nxt;
    logic          w_hold_nxt_p;
    logic          w_repeat_nxt;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s        = ACTIVE_LOW ? ~r_sync2 : r_sync2;
    assign w_db_inc   = (r_db_cnt == C_MAX) ? r_db_cnt : r_db_cnt + C_ONE;
    assign w_hold_inc = (r_hold_cnt == C_MAX) ? r_hold_cnt : r_hold_cnt + C_ONE;

    // Next-state, counter and pulse decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_ret_held_nxt = r_ret_held;
        w_db_nxt       = r_db_cnt;
        w_hold_nxt     = r_hold_cnt;
        w_level_nxt    = r_level;
        w_press_nxt    = 1'b0;
        w_release_nxt  = 1'b0;
        w_hold_nxt_p   = 1'b0;
        w_repeat_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_s) begin
                    if (DB_ONE) begin
                        w_state_nxt = PRESSED;
                        w_level_nxt = 1'b1;
                        w_press_nxt = 1'b1;
                        w_db_nxt    = {CW{1'b0}};
                        w_hold_nxt  = {CW{1'b0}};
                    end else begin
                        w_state_nxt = ARM;
                        w_db_nxt    = C_ONE;
                    end
                end else begin
                    w_db_nxt = {CW{1'b0}};
                end
            end
            ARM: begin
                if (w_s) begin
                    if (w_db_inc >= C_DB) begin
                        w_state_nxt = PRESSED;
                        w_level_nxt = 1'b1;
                        w_press_nxt = 1'b1;
                        w_db_nxt    = {CW{1'b0}};
                        w_hold_nxt  = {CW{1'b0}};
                    end else begin
                        w_db_nxt = w_db_inc;
                    end
                end else begin
                    w_state_nxt = IDLE;
                    w_db_nxt    = {CW{1'b0}};
                end
            end
            PRESSED, HELD: begin
                if (w_s) begin
                    if (r_state == PRESSED) begin
                        if (w_hold_inc >= C_HOLD) begin
                            w_state_nxt  = HELD;
                            w_hold_nxt_p = 1'b1;
                            w_repeat_nxt = 1'b1;
                            w_hold_nxt   = {CW{1'b0}};
                        end else begin
                            w_hold_nxt = w_hold_inc;
                        end
                    end else if (RPT_EN) begin
                        if (w_hold_inc >= C_RPT) begin
                            w_repeat_nxt = 1'b1;
                            w_hold_nxt   = {CW{1'b0}};
                        end else begin
                            w_hold_nxt = w_hold_inc;
                        end
                    end else begin
                        w_hold_nxt = r_hold_cnt;
                    end
                end else begin
                    w_ret_held_nxt = (r_state == HELD);
                    if (DB_ONE) begin
                        w_state_nxt    = IDLE;
                        w_level_nxt    = 1'b0;
                        w_release_nxt  = 1'b1;
                        w_db_nxt       = {CW{1'b0}};
                        w_hold_nxt     = {CW{1'b0}};
                        w_ret_held_nxt = 1'b0;
                    end else begin
                        w_state_nxt = REL_WAIT;
                        w_db_nxt    = C_ONE;
                    end
                end
            end
            REL_WAIT: begin
                // hold_cnt is deliberately untouched so a bounce resumes the long-press count.
                if (!w_s) begin
                    if (w_db_inc >= C_DB) begin
                        w_state_nxt    = IDLE;
                        w_level_nxt    = 1'b0;
                        w_release_nxt  = 1'b1;
                        w_db_nxt       = {CW{1'b0}};
                        w_hold_nxt     = {CW{1'b0}};
                        w_ret_held_nxt = 1'b0;
                    end else begin
                        w_db_nxt = w_db_inc;
                    end
                end else begin
                    w_state_nxt = r_ret_held ? HELD : PRESSED;
                    w_db_nxt    = {CW{1'b0}};
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_ret_held_nxt = 1'b0;
                w_db_nxt       = {CW{1'b0}};
                w_hold_nxt     = {CW{1'b0}};
                w_level_nxt    = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ret_held <= 1'b0;
            r_db_cnt   <= {CW{1'b0}};
            r_hold_cnt <= {CW{1'b0}};
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_hold     <= 1'b0;
            r_repeat   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ret_held <= w_ret_held_nxt;
            r_db_cnt   <= w_db_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_level    <= w_level_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
            r_hold     <= w_hold_nxt_p;
            r_repeat   <= w_repeat_nxt;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_hold    = r_hold;
    assign o_repeat  = r_repeat;

endmodule

// File: rtl/btn_debounce_multi.sv
// N_CH independent button conditioners; output bit g belongs to input bit g.
module btn_debounce_multi
    import btn_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DB_CYC     = DB_CYC_DEF,
    parameter int HOLD_CYC   = HOLD_CYC_DEF,
    parameter int RPT_CYC    = RPT_CYC_DEF,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] i_btn,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_hold,
    output logic [N_CH-1:0] o_repeat
);

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            btn_debounce_ch #(
                .DB_CYC    (DB_CYC),
                .HOLD_CYC  (HOLD_CYC),
                .RPT_CYC   (RPT_CYC),
                .ACTIVE_LOW(ACTIVE_LOW)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .i_btn    (i_btn[g]),
                .o_level  (o_level[g]),
                .o_press  (o_press[g]),
                .o_release(o_release[g]),
                .o_hold   (o_hold[g]),
                .o_repeat (o_repeat[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Self-checking bench: table-driven press/release vectors, a cycle-stamped
// scoreboard of expected output events, and hand-written corner sequences.
module tb_btn_debounce_multi;

    localparam int N_CH = 2;
    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int RPT  = 8;
    localparam int LAT  = DB + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] i_btn;
    logic [1:0] a_level, a_press, a_release, a_hold, a_repeat;
    logic [1:0] b_level, b_press, b_release, b_hold, b_repeat;

    always #5 clk = ~clk;

    btn_debounce_multi #(.N_CH(N_CH), .DB_CYC(DB), .HOLD_CYC(HOLD), .RPT_CYC(RPT), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .i_btn(i_btn),
        .o_level(a_level), .o_press(a_press), .o_release(a_release),
        .o_hold(a_hold), .o_repeat(a_repeat)
    );

    btn_debounce_multi #(.N_CH(N_CH), .DB_CYC(DB), .HOLD_CYC(HOLD), .RPT_CYC(0), .ACTIVE_LOW(1'b0)) dut_norpt (
        .clk(clk), .rst(rst), .i_btn(i_btn),
        .o_level(b_level), .o_press(b_press), .o_release(b_release),
        .o_hold(b_hold), .o_repeat(b_repeat)
    );

    typedef struct {
        int         at;
        string      tag;
        logic [9:0] exp;
    } sb_t;

    typedef struct {
        logic [1:0] btn;
        int         ncyc;
        int         ev_off;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
    } vec_t;

    sb_t  q[$];
    vec_t tbl[6];
    int   cyc;
    int   n_chk;
    int   n_fail;
    int   c_press[2], c_rel[2], c_hold[2], c_rpt[2], c_lvl[2];
    int   d_press[2], d_rel[2], d_hold[2], d_rpt[2];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic push(input int at, input string tag, input logic [1:0] lvl, input logic [1:0] prs,
                        input logic [1:0] rel, input logic [1:0] hld, input logic [1:0] rpt);
        sb_t e;
        e.at  = at;
        e.tag = tag;
        e.exp = {lvl, prs, rel, hld, rpt};
        q.push_back(e);
    endtask

    task automatic clr_counts();
        for (int c = 0; c < 2; c++) begin
            c_press[c] = 0; c_rel[c] = 0; c_hold[c] = 0; c_rpt[c] = 0; c_lvl[c] = 0;
            d_press[c] = 0; d_rel[c] = 0; d_hold[c] = 0; d_rpt[c] = 0;
        end
    endtask

    task automatic step();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < 2; c++) begin
            c_press[c] += int'(a_press[c]);
            c_rel[c]   += int'(a_release[c]);
            c_hold[c]  += int'(a_hold[c]);
            c_rpt[c]   += int'(a_repeat[c]);
            c_lvl[c]   += int'(a_level[c]);
            d_press[c] += int'(b_press[c]);
            d_rel[c]   += int'(b_release[c]);
            d_hold[c]  += int'(b_hold[c]);
            d_rpt[c]   += int'(b_repeat[c]);
        end
        while (q.size() > 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            if (e.at < cyc) begin
                chk({e.tag, "_missed"}, cyc, e.at);
            end else begin
                chk(e.tag, int'({a_level, a_press, a_release, a_hold, a_repeat}), int'(e.exp));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int cr;
        tbl[0] = '{btn: 2'b01, ncyc: 20, ev_off: LAT, lvl: 2'b01, prs: 2'b01, rel: 2'b00};
        tbl[1] = '{btn: 2'b00, ncyc: 20, ev_off: LAT, lvl: 2'b00, prs: 2'b00, rel: 2'b01};
        tbl[2] = '{btn: 2'b10, ncyc: 20, ev_off: LAT, lvl: 2'b10, prs: 2'b10, rel: 2'b00};
        tbl[3] = '{btn: 2'b00, ncyc: 20, ev_off: LAT, lvl: 2'b00, prs: 2'b00, rel: 2'b10};
        tbl[4] = '{btn: 2'b11, ncyc: 20, ev_off: LAT, lvl: 2'b11, prs: 2'b11, rel: 2'b00};
        tbl[5] = '{btn: 2'b00, ncyc: 20, ev_off: LAT, lvl: 2'b00, prs: 2'b00, rel: 2'b11};
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        clr_counts();

        // Reset state
        i_btn = 2'b00;
        rst   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({a_level, a_press, a_release, a_hold, a_repeat}), 0);
        chk("reset_outputs_norpt", int'({b_level, b_press, b_release, b_hold, b_repeat}), 0);
        #2;
        rst = 1'b0;
        repeat (3) step();

        // Clean press/release vectors on each channel and both together
        for (int r = 0; r < 6; r++) begin
            c0 = cyc;
            clr_counts();
            i_btn = tbl[r].btn;
            push(c0 + tbl[r].ev_off, $sformatf("vec%0d_event", r), tbl[r].lvl, tbl[r].prs, tbl[r].rel, 2'b00, 2'b00);
            repeat (tbl[r].ncyc) step();
            chk($sformatf("vec%0d_level_end", r), int'(a_level), int'(tbl[r].lvl));
            chk($sformatf("vec%0d_press_count", r), c_press[0] + c_press[1], $countones(tbl[r].prs));
            chk($sformatf("vec%0d_release_count", r), c_rel[0] + c_rel[1], $countones(tbl[r].rel));
        end

        // Bounce reject: runs of at most two high samples
        clr_counts();
        for (int i = 0; i < 30; i++) begin
            i_btn = {1'b0, (i % 3) != 2};
            step();
        end
        i_btn = 2'b00;
        repeat (8) step();
        chk("bounce_press", c_press[0], 0);
        chk("bounce_level", c_lvl[0], 0);
        chk("bounce_release", c_rel[0], 0);

        // Release glitch while pressed
        c0 = cyc;
        clr_counts();
        i_btn = 2'b01;
        push(c0 + LAT, "glitch_press", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        repeat (10) step();
        i_btn = 2'b00;
        repeat (2) step();
        i_btn = 2'b01;
        repeat (6) step();
        i_btn = 2'b00;
        push(c0 + 18 + LAT, "glitch_final_release", 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        repeat (10) step();
        chk("glitch_press_count", c_press[0], 1);
        chk("glitch_release_count", c_rel[0], 1);
        chk("glitch_level_cycles", c_lvl[0], 18);
        chk("glitch_hold_count", c_hold[0], 0);

        // Long press with auto-repeat
        c0 = cyc;
        clr_counts();
        i_btn = 2'b01;
        push(c0 + LAT, "lp_press", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        push(c0 + LAT + HOLD, "lp_hold", 2'b01, 2'b00, 2'b00, 2'b01, 2'b01);
        for (int k = 1; k <= 4; k++) begin
            push(c0 + LAT + HOLD + k * RPT, $sformatf("lp_repeat%0d", k), 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
        end
        repeat (62) step();
        i_btn = 2'b00;
        push(c0 + 62 + LAT, "lp_release", 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        repeat (14) step();
        chk("lp_hold_count", c_hold[0], 1);
        chk("lp_repeat_count", c_rpt[0], 5);
        chk("lp_norpt_hold_count", d_hold[0], 1);
        chk("lp_norpt_repeat_count", d_rpt[0], 1);
        chk("lp_norpt_press_release", d_press[0] * 10 + d_rel[0], 11);

        // Async reset with ch1 in HELD and ch0 in ARM
        c0 = cyc;
        clr_counts();
        i_btn = 2'b10;
        push(c0 + LAT, "rst_ch1_press", 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        push(c0 + LAT + HOLD, "rst_ch1_hold", 2'b10, 2'b00, 2'b00, 2'b10, 2'b10);
        repeat (27) step();
        i_btn = 2'b11;
        repeat (4) step();
        chk("rst_pre_level", int'(a_level), 2);
        chk("rst_pre_ch0_press", c_press[0], 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_immediate", int'({a_level, a_press, a_release, a_hold, a_repeat}), 0);
        chk("rst_immediate_norpt", int'({b_level, b_press, b_release, b_hold, b_repeat}), 0);
        repeat (2) step();
        chk("rst_held_level", int'(a_level), 0);
        #2;
        rst = 1'b0;
        cr = cyc;
        clr_counts();
        push(cr + LAT, "rst_repress", 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        repeat (10) step();
        chk("rst_no_release", c_rel[0] + c_rel[1], 0);
        chk("rst_repress_ch0", c_press[0], 1);
        chk("rst_repress_ch1", c_press[1], 1);
        c0 = cyc;
        i_btn = 2'b00;
        push(c0 + LAT, "rst_final_release", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        repeat (10) step();

        while (q.size() > 0) begin
            chk({q[0].tag, "_never_reached"}, cyc, q[0].at);
            void'(q.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
